// File: rtl/sad_result_ctrl.sv
// Arbiter/sequencer in front of the single-port SAD result SRAM: shares it between
// the datapath writer and host reader, and runs bulk clear and min-SAD search.
module sad_result_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Wr_Valid,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic              Wr_Ready,
    input  logic              Rd_Req,
    input  logic [ADDR_W-1:0] Rd_Addr,
    output logic              Rd_Ready,
    output logic              Rd_Valid,
    output logic [DATA_W-1:0] Rd_Data,
    input  logic              Srch_Start,
    input  logic [ADDR_W-1:0] Srch_Last,
    output logic              Srch_Busy,
    output logic              Srch_Done,
    output logic [DATA_W-1:0] Min_Value,
    output logic [ADDR_W-1:0] Min_Index,
    input  logic              Clr_Start,
    output logic              Clr_Busy,
    output logic              Clr_Done,
    output logic              Sram_En,
    output logic              Sram_RW,
    output logic [ADDR_W-1:0] Sram_Addr,
    output logic [DATA_W-1:0] Sram_DataIn,
    input  logic [DATA_W-1:0] Sram_DataOut
);

    typedef enum logic [1:0] {IDLE, SEARCH, CLEAR} state_t;
    typedef enum logic {GNT_WR, GNT_RD} grant_t;

    state_t            state, state_nxt;
    grant_t            last_grant;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] srch_last;
    logic              issue_done;
    logic              rcv_vld;
    logic              rcv_first;
    logic [ADDR_W-1:0] rcv_idx;
    logic [DATA_W-1:0] work_min;
    logic [ADDR_W-1:0] work_idx;

    logic              idle_ok, start_any, wr_gnt, rd_gnt;
    logic              srch_issue, clr_wr, srch_end, clr_end, take;
    logic [DATA_W-1:0] cand_val;
    logic [ADDR_W-1:0] cand_idx;

    always_comb begin
        idle_ok   = (state == IDLE) && !Rst;
        start_any = Clr_Start || Srch_Start;
        wr_gnt    = idle_ok && !start_any && Wr_Valid && (!Rd_Req || last_grant == GNT_RD);
        rd_gnt    = idle_ok && !start_any && Rd_Req && (!Wr_Valid || last_grant == GNT_WR);
        srch_issue = (state == SEARCH) && !issue_done && !Rst;
        clr_wr     = (state == CLEAR) && !Rst;
        srch_end   = (state == SEARCH) && rcv_vld && (rcv_idx == srch_last);
        clr_end    = (state == CLEAR) && (cnt == '1);

        // First datum seeds the minimum; strict less-than keeps the lowest index on ties
        take     = rcv_first || (Sram_DataOut < work_min);
        cand_val = take ? Sram_DataOut : work_min;
        cand_idx = take ? rcv_idx : work_idx;

        state_nxt = state;
        case (state)
            IDLE:    if (Clr_Start) state_nxt = CLEAR;
                     else if (Srch_Start) state_nxt = SEARCH;
            SEARCH:  if (srch_end) state_nxt = IDLE;
            CLEAR:   if (clr_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        Sram_En     = 1'b0;
        Sram_RW     = 1'b0;
        Sram_Addr   = '0;
        Sram_DataIn = '0;
        if (wr_gnt) begin
            Sram_En     = 1'b1;
            Sram_RW     = 1'b1;
            Sram_Addr   = Wr_Addr;
            Sram_DataIn = Wr_Data;
        end else if (rd_gnt) begin
            Sram_En   = 1'b1;
            Sram_Addr = Rd_Addr;
        end else if (srch_issue) begin
            Sram_En   = 1'b1;
            Sram_Addr = cnt;
        end else if (clr_wr) begin
            Sram_En   = 1'b1;
            Sram_RW   = 1'b1;
            Sram_Addr = cnt;
        end
    end

    assign Wr_Ready  = wr_gnt;
    assign Rd_Ready  = rd_gnt;
    assign Rd_Data   = Sram_DataOut;
    assign Srch_Busy = (state == SEARCH);
    assign Clr_Busy  = (state == CLEAR);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            last_grant <= GNT_RD;
            cnt        <= '0;
            srch_last  <= '0;
            issue_done <= 1'b0;
            rcv_vld    <= 1'b0;
            rcv_first  <= 1'b0;
            rcv_idx    <= '0;
            work_min   <= '0;
            work_idx   <= '0;
            Rd_Valid   <= 1'b0;
            Srch_Done  <= 1'b0;
            Clr_Done   <= 1'b0;
            Min_Value  <= '0;
            Min_Index  <= '0;
        end else begin
            state     <= state_nxt;
            Rd_Valid  <= rd_gnt;
            Srch_Done <= srch_end;
            Clr_Done  <= clr_end;
            rcv_vld   <= srch_issue;
            rcv_idx   <= cnt;
            rcv_first <= (cnt == '0);
            if (wr_gnt)
                last_grant <= GNT_WR;
            else if (rd_gnt)
                last_grant <= GNT_RD;

            case (state)
                IDLE: begin
                    cnt        <= '0;
                    issue_done <= 1'b0;
                    if (Srch_Start && !Clr_Start)
                        srch_last <= Srch_Last;
                end
                SEARCH: begin
                    if (srch_issue) begin
                        if (cnt == srch_last)
                            issue_done <= 1'b1;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                CLEAR:   cnt <= cnt + 1'b1;
                default: cnt <= '0;
            endcase

            if (rcv_vld) begin
                work_min <= cand_val;
                work_idx <= cand_idx;
            end
            if (srch_end) begin
                Min_Value <= cand_val;
                Min_Index <= cand_idx;
            end
        end
    end

endmodule

// File: tb/tb_sad_result_ctrl.sv
// Scoreboard bench for sad_result_ctrl with a behavioural registered-read SRAM.
module tb_sad_result_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Wr_Valid = 1'b0;
    logic [6:0]  Wr_Addr = '0;
    logic [31:0] Wr_Data = '0;
    logic        Wr_Ready;
    logic        Rd_Req = 1'b0;
    logic [6:0]  Rd_Addr = '0;
    logic        Rd_Ready;
    logic        Rd_Valid;
    logic [31:0] Rd_Data;
    logic        Srch_Start = 1'b0;
    logic [6:0]  Srch_Last = '0;
    logic        Srch_Busy, Srch_Done;
    logic [31:0] Min_Value;
    logic [6:0]  Min_Index;
    logic        Clr_Start = 1'b0;
    logic        Clr_Busy, Clr_Done;
    logic        Sram_En, Sram_RW;
    logic [6:0]  Sram_Addr;
    logic [31:0] Sram_DataIn;
    logic [31:0] Sram_DataOut;

    sad_result_ctrl #(.ADDR_W(7), .DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .Wr_Valid(Wr_Valid), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Wr_Ready(Wr_Ready),
        .Rd_Req(Rd_Req), .Rd_Addr(Rd_Addr), .Rd_Ready(Rd_Ready),
        .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data),
        .Srch_Start(Srch_Start), .Srch_Last(Srch_Last), .Srch_Busy(Srch_Busy),
        .Srch_Done(Srch_Done), .Min_Value(Min_Value), .Min_Index(Min_Index),
        .Clr_Start(Clr_Start), .Clr_Busy(Clr_Busy), .Clr_Done(Clr_Done),
        .Sram_En(Sram_En), .Sram_RW(Sram_RW), .Sram_Addr(Sram_Addr),
        .Sram_DataIn(Sram_DataIn), .Sram_DataOut(Sram_DataOut)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [31:0] mem [128];
    logic [31:0] sram_q = '0;
    assign Sram_DataOut = sram_q;
    always @(posedge Clk) begin
        if (Sram_En && Sram_RW) mem[Sram_Addr] <= Sram_DataIn;
        sram_q <= (Sram_En && !Sram_RW) ? mem[Sram_Addr] : 32'h0;
    end

    typedef struct { logic [31:0] data; int unsigned cyc; } rd_exp_t;
    typedef struct { logic [31:0] val; logic [6:0] idx; int unsigned cyc; } srch_exp_t;
    rd_exp_t     rd_q[$];
    srch_exp_t   srch_q[$];
    int unsigned clr_q[$];

    int n_pass = 0;
    int n_total = 0;
    int srch_done_cnt = 0;
    int clr_done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT output event must match the oldest queued expectation
    always @(negedge Clk) begin
        rd_exp_t   re;
        srch_exp_t se;
        int unsigned ce;
        if (Rd_Valid) begin
            if (rd_q.size() == 0) fail("rd_unexpected");
            else begin
                re = rd_q.pop_front();
                chk("rd_data", Rd_Data, re.data);
                chk("rd_cycle", cyc, re.cyc);
            end
        end
        if (Srch_Done) begin
            srch_done_cnt++;
            if (srch_q.size() == 0) fail("srch_done_unexpected");
            else begin
                se = srch_q.pop_front();
                chk("min_value", Min_Value, se.val);
                chk("min_index", {25'h0, Min_Index}, {25'h0, se.idx});
                chk("srch_done_cycle", cyc, se.cyc);
            end
        end
        if (Clr_Done) begin
            clr_done_cnt++;
            if (clr_q.size() == 0) fail("clr_done_unexpected");
            else begin
                ce = clr_q.pop_front();
                chk("clr_done_cycle", cyc, ce);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d);
        bit granted = 0;
        Wr_Valid = 1'b1; Wr_Addr = a; Wr_Data = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Wr_Ready) begin granted = 1; break; end
            step();
        end
        if (!granted) fail("wr_grant_timeout");
        step();
        Wr_Valid = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a, input logic [31:0] exp);
        bit granted = 0;
        rd_exp_t e;
        Rd_Req = 1'b1; Rd_Addr = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Rd_Ready) begin granted = 1; break; end
            step();
        end
        if (!granted) fail("rd_grant_timeout");
        else begin
            e.data = exp; e.cyc = cyc + 1;
            rd_q.push_back(e);
        end
        step();
        Rd_Req = 1'b0;
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        repeat (3) step();
        Rst = 1'b0;
    endtask

    task automatic wait_clr_done();
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Clr_Done) begin seen = 1; break; end
        end
        if (!seen) fail("clr_done_timeout");
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s, c;
        int sd0, busy_cycles, viol;
        srch_exp_t se;
        rd_exp_t   re;
        logic [6:0]  t2_wa [4];
        logic [31:0] t2_wd [4];
        logic [6:0]  t2_ra [4];
        logic [3:0]  t2_exp_w;
        logic [31:0] t3_data [4];

        // Reset: requests and a start pulse present, nothing may reach the SRAM
        Wr_Valid = 1'b1; Rd_Req = 1'b1; Clr_Start = 1'b1;
        @(negedge Clk);
        chk("rst_sram_en", Sram_En, 0);
        chk("rst_wr_ready", Wr_Ready, 0);
        step();
        Wr_Valid = 1'b0; Rd_Req = 1'b0; Clr_Start = 1'b0;
        apply_reset();
        @(negedge Clk);
        chk("rst_rd_valid", Rd_Valid, 0);
        chk("rst_srch_busy", Srch_Busy, 0);
        chk("rst_clr_busy", Clr_Busy, 0);
        chk("rst_min_value", Min_Value, 0);
        chk("rst_min_index", {25'h0, Min_Index}, 0);
        step();

        // Single write then read of address 5
        Wr_Valid = 1'b1; Wr_Addr = 7'd5; Wr_Data = 32'h10;
        @(negedge Clk);
        chk("t1_wr_ready", Wr_Ready, 1);
        chk("t1_sram_rw", Sram_RW, 1);
        chk("t1_sram_addr", {25'h0, Sram_Addr}, 5);
        chk("t1_sram_din", Sram_DataIn, 32'h10);
        step();
        Wr_Valid = 1'b0; Rd_Req = 1'b1; Rd_Addr = 7'd5;
        @(negedge Clk);
        chk("t1_rd_ready", Rd_Ready, 1);
        chk("t1_rd_sram_rw", Sram_RW, 0);
        chk("t1_rd_sram_din", Sram_DataIn, 0);
        re.data = 32'h10; re.cyc = cyc + 1;
        rd_q.push_back(re);
        step();
        Rd_Req = 1'b0;
        step();

        // Both requesters held: round-robin W,R,W,R starting from reset state
        apply_reset();
        t2_wa = '{7'd10, 7'd11, 7'd11, 7'd12};
        t2_wd = '{32'hA1, 32'hB2, 32'hB2, 32'hC3};
        t2_ra = '{7'd10, 7'd10, 7'd11, 7'd11};
        t2_exp_w = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            Wr_Valid = 1'b1; Rd_Req = 1'b1;
            Wr_Addr = t2_wa[i]; Wr_Data = t2_wd[i]; Rd_Addr = t2_ra[i];
            @(negedge Clk);
            chk($sformatf("t2_wr_ready_%0d", i), Wr_Ready, t2_exp_w[i]);
            chk($sformatf("t2_rd_ready_%0d", i), Rd_Ready, !t2_exp_w[i]);
            if (!t2_exp_w[i]) begin
                re.data = (i == 1) ? 32'hA1 : 32'hB2;
                re.cyc = cyc + 1;
                rd_q.push_back(re);
            end
            step();
        end
        Rd_Req = 1'b0;
        @(negedge Clk);
        chk("t2_wr_alone", Wr_Ready, 1);
        step();
        Wr_Valid = 1'b0;
        do_read(7'd12, 32'hC3);

        // Search over {9,3,7,3}: tie on 3 keeps index 1
        t3_data = '{32'd9, 32'd3, 32'd7, 32'd3};
        for (int i = 0; i < 4; i++) do_write(7'(i), t3_data[i]);
        Srch_Start = 1'b1; Srch_Last = 7'd3;
        s = cyc;
        se.val = 32'd3; se.idx = 7'd1; se.cyc = s + 6;
        srch_q.push_back(se);
        step();
        Srch_Start = 1'b0; Srch_Last = 7'd0;
        @(negedge Clk);
        chk("t3_srch_busy", Srch_Busy, 1);
        sd0 = srch_done_cnt;
        for (int i = 0; i < 30 && srch_done_cnt == sd0; i++) step();
        if (srch_done_cnt == sd0) fail("t3_srch_timeout");
        @(negedge Clk);
        chk("t3_busy_after", Srch_Busy, 0);
        step();

        // Single-entry search
        Srch_Start = 1'b1; Srch_Last = 7'd0;
        s = cyc;
        se.val = 32'd9; se.idx = 7'd0; se.cyc = s + 3;
        srch_q.push_back(se);
        step();
        Srch_Start = 1'b0;
        sd0 = srch_done_cnt;
        for (int i = 0; i < 30 && srch_done_cnt == sd0; i++) step();
        if (srch_done_cnt == sd0) fail("t3b_srch_timeout");
        step();

        // Fill then clear; no grants while clearing
        for (int i = 0; i < 128; i++) do_write(7'(i), 32'h1000 + 32'(i));
        Clr_Start = 1'b1;
        c = cyc;
        clr_q.push_back(c + 129);
        step();
        Clr_Start = 1'b0;
        busy_cycles = 0; viol = 0;
        for (int i = 0; i < 300; i++) begin
            Wr_Valid = (cyc <= c + 128); Rd_Req = (cyc <= c + 128);
            Wr_Addr = 7'd3; Wr_Data = 32'hDEAD; Rd_Addr = 7'd3;
            @(negedge Clk);
            if (Clr_Done) break;
            if (Clr_Busy) begin
                busy_cycles++;
                if (Wr_Ready || Rd_Ready) viol++;
            end
            step();
        end
        step();
        Wr_Valid = 1'b0; Rd_Req = 1'b0;
        chk("t4_busy_cycles", busy_cycles, 128);
        chk("t4_grant_violations", viol, 0);
        do_read(7'd0, 32'h0);
        do_read(7'd64, 32'h0);
        do_read(7'd127, 32'h0);

        // Simultaneous starts: clear wins; a start during clear is ignored
        sd0 = srch_done_cnt;
        Clr_Start = 1'b1; Srch_Start = 1'b1; Srch_Last = 7'd5;
        c = cyc;
        clr_q.push_back(c + 129);
        step();
        Clr_Start = 1'b0; Srch_Start = 1'b0;
        repeat (10) step();
        Srch_Start = 1'b1;
        step();
        Srch_Start = 1'b0;
        wait_clr_done();
        repeat (10) step();
        @(negedge Clk);
        chk("t5_no_srch_done", srch_done_cnt, sd0);
        chk("t5_srch_busy", Srch_Busy, 0);
        chk("t5_min_hold", Min_Value, 32'd9);
        step();

        // Reset while the search is reading address 40
        sd0 = srch_done_cnt;
        Srch_Start = 1'b1; Srch_Last = 7'd127;
        s = cyc;
        step();
        Srch_Start = 1'b0;
        while (cyc < s + 41) step();
        Rst = 1'b1;
        @(negedge Clk);
        chk("t6_sram_en_in_rst", Sram_En, 0);
        step();
        Rst = 1'b0;
        @(negedge Clk);
        chk("t6_srch_busy", Srch_Busy, 0);
        chk("t6_min_value", Min_Value, 0);
        chk("t6_rd_valid", Rd_Valid, 0);
        step();
        repeat (100) step();
        chk("t6_no_srch_done", srch_done_cnt, sd0);
        do_write(7'd7, 32'h55);
        do_read(7'd7, 32'h55);

        repeat (5) step();
        chk("end_rd_q_empty", rd_q.size(), 0);
        chk("end_srch_q_empty", srch_q.size(), 0);
        chk("end_clr_q_empty", clr_q.size(), 0);
        chk("end_clr_done_cnt", clr_done_cnt, 2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sad_result_ctrl.md
Name: sad_result_ctrl

Overview:
Controller and arbiter in front of the single-port 128x32 SAD result SRAM (registered read, one access per cycle). It shares the SRAM between the SAD datapath write requester and a host read requester, and adds two sequenced operations: a bulk clear, and a min-SAD search that returns the smallest stored SAD and its index. All SRAM traffic in the SAD subsystem goes through this block.

Parameters:
ADDR_W, 7, SRAM address width; depth = 2**ADDR_W
DATA_W, 32, SAD word width

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
Wr_Valid  in  1  SAD datapath write request
Wr_Addr  in  ADDR_W  write address
Wr_Data  in  DATA_W  write data
Wr_Ready  out  1  write accepted this cycle (combinational grant)
Rd_Req  in  1  host read request
Rd_Addr  in  ADDR_W  read address
Rd_Ready  out  1  read accepted this cycle (combinational grant)
Rd_Valid  out  1  Rd_Data valid (registered)
Rd_Data  out  DATA_W  read data
Srch_Start  in  1  start min search, 1-cycle pulse
Srch_Last  in  ADDR_W  last index searched (inclusive), sampled at start
Srch_Busy  out  1  search in progress
Srch_Done  out  1  1-cycle pulse, Min_* valid
Min_Value  out  DATA_W  smallest SAD found
Min_Index  out  ADDR_W  address of Min_Value
Clr_Start  in  1  start clear of all entries, 1-cycle pulse
Clr_Busy  out  1  clear in progress
Clr_Done  out  1  1-cycle pulse
Sram_En  out  1  SRAM enable
Sram_RW  out  1  1 = write, 0 = read
Sram_Addr  out  ADDR_W  SRAM address
Sram_DataIn  out  DATA_W  SRAM write data
Sram_DataOut  in  DATA_W  SRAM registered read data (0 on non-read cycles)

Behaviour:
- FSM states: IDLE, SEARCH, CLEAR.
- Reset: state IDLE. Registered outputs (Rd_Valid, Srch_Done, Clr_Done, Min_Value, Min_Index, Busy flags) are 0. Last_Grant = RD. Sram_En = 0 while Rst is high. Reset mid-search or mid-clear aborts at once; no Done pulse is issued.
- SRAM controls are combinational from the current state and grant. Sram_DataIn is 0 except on write cycles.
- IDLE priority, evaluated each cycle: Clr_Start > Srch_Start > port requests. A start pulse moves the FSM next cycle. Wr_Ready and Rd_Ready are 0 in the start cycle. If both starts are asserted, clear wins and the search is dropped.
- IDLE arbitration with no start:
  - Single requester: it is granted.
  - Both requesting: the one not granted last is granted (round-robin). Last_Grant updates on each grant.
- Write grant: Sram_En = 1, RW = 1, Addr = Wr_Addr, DataIn = Wr_Data.
- Read grant in cycle N: Sram_En = 1, RW = 0, Addr = Rd_Addr. Rd_Valid = 1 in cycle N+1, with Rd_Data = Sram_DataOut. Back-to-back reads give one result per cycle.
- SEARCH and CLEAR: Wr_Ready = Rd_Ready = 0. Srch_Start and Clr_Start are ignored while Srch_Busy or Clr_Busy is set.
- SEARCH, start accepted in cycle S with L = Srch_Last:
  - Reads of addresses 0..L are issued in cycles S+1..S+1+L.
  - Data for address k arrives in cycle S+2+k.
  - The first datum initialises Min. Later data replace Min only if strictly less, so ties keep the lowest index. Comparison is unsigned DATA_W.
  - Srch_Done pulses in cycle S+3+L. Srch_Busy is high for cycles S+1..S+2+L. State is IDLE in cycle S+3+L.
  - Min_* hold their value until the next search completes or reset.
  - L = 0 is a legal single-entry search.
- CLEAR, accepted in cycle C:
  - Writes 0 to addresses 0..DEPTH-1 in cycles C+1..C+DEPTH.
  - Clr_Done pulses in cycle C+DEPTH+1. Clr_Busy is high for C+1..C+DEPTH.
  - The address counter must not wrap into a second pass.
- Requesters hold requests while Ready is 0. No request is lost or duplicated.

Test Plan:
- Reset, then write 0x10 to address 5 and read address 5: Wr_Ready = 1; Rd_Valid one cycle after Rd_Ready; Rd_Data = 0x10.
- Wr_Valid and Rd_Req held together for 4 cycles (after reset): grants go W, R, W, R; each read returns the data written before it.
- Write {9,3,7,3} at addresses 0..3, Srch_Start with Srch_Last = 3 at cycle S: Srch_Done at S+6, Min_Value = 3, Min_Index = 1 (tie keeps the lowest index).
- Write nonzero data to all 128 entries, then Clr_Start at cycle C: Clr_Done at C+129; reads of addresses 0, 64 and 127 return 0; no grants during Clr_Busy.
- Clr_Start and Srch_Start in the same cycle: only the clear runs and Srch_Done never pulses. A Srch_Start during Clr_Busy is ignored.
- Rst asserted mid-search at address 40: next cycle state is IDLE, Srch_Busy = 0, Min_Value = 0, no Srch_Done; a subsequent write and read work normally.
